// File: rtl/wishbone_pkg.sv
// Shared types and bus widths for the Wishbone initiator and its timeout helper.
package wishbone_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } wb_state_e;

endpackage

// File: rtl/wishbone_master_if.sv
// Command/response and Wishbone bus signals of the initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface wishbone_master_if;
  import wishbone_pkg::*;

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [WB_SEL_W-1:0] cmd_sel_i;
  logic [WB_ADR_W-1:0] cmd_adr_i;
  logic [WB_DAT_W-1:0] cmd_dat_i;

  logic                rsp_valid_o;
  logic [WB_DAT_W-1:0] rsp_dat_o;
  logic                rsp_err_o;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic [WB_DAT_W-1:0] wbm_dat_i;
  logic                wbm_ack_i;
  logic                wbm_err_i;
  logic                wbm_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i
  );

endinterface

// File: rtl/wishbone_timeout.sv
// Saturating cycle counter that flags the edge on which a bus cycle has run TIMEOUT_CYCLES cycles.
module wishbone_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_count_q;
  logic [CntW-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count_q;
    if (i_clear) begin
      w_count_d = '0;
    end else if (i_enable && (r_count_q != MaxCnt)) begin
      w_count_d = r_count_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= w_count_d;
    end
  end

  // High on the edge where the count would reach TIMEOUT_CYCLES.
  assign o_expired = i_enable && !i_clear && (r_count_q == LastCnt);

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus cycle, one response
// pulse, with every cycle bounded by a timeout.
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wishbone_master_if.master     bus
);

  wb_state_e           r_state_q, w_state_d;
  logic                r_cmd_ready_q, w_cmd_ready_d;
  logic                r_rsp_valid_q, w_rsp_valid_d;
  logic                r_rsp_err_q, w_rsp_err_d;
  logic [WB_DAT_W-1:0] r_rsp_dat_q, w_rsp_dat_d;
  logic                r_cyc_q, w_cyc_d;
  logic                r_stb_q, w_stb_d;
  logic                r_we_q, w_we_d;
  logic [WB_SEL_W-1:0] r_sel_q, w_sel_d;
  logic [WB_ADR_W-1:0] r_adr_q, w_adr_d;
  logic [WB_DAT_W-1:0] r_dat_q, w_dat_d;

  logic w_tmo_clear;
  logic w_tmo_enable;
  logic w_tmo_expired;

  wishbone_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_i),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_tmo_enable),
    .o_expired (w_tmo_expired)
  );

  always_comb begin
    w_state_d     = r_state_q;
    w_cmd_ready_d = r_cmd_ready_q;
    w_rsp_valid_d = 1'b0;
    w_rsp_err_d   = r_rsp_err_q;
    w_rsp_dat_d   = r_rsp_dat_q;
    w_cyc_d       = r_cyc_q;
    w_stb_d       = r_stb_q;
    w_we_d        = r_we_q;
    w_sel_d       = r_sel_q;
    w_adr_d       = r_adr_q;
    w_dat_d       = r_dat_q;
    w_tmo_clear   = 1'b0;
    w_tmo_enable  = 1'b0;

    unique case (r_state_q)
      StIdle: begin
        w_cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && r_cmd_ready_q) begin
          w_we_d        = bus.cmd_we_i;
          w_sel_d       = bus.cmd_sel_i;
          w_adr_d       = bus.cmd_adr_i;
          w_dat_d       = bus.cmd_dat_i;
          w_cyc_d       = 1'b1;
          w_stb_d       = 1'b1;
          w_cmd_ready_d = 1'b0;
          w_tmo_clear   = 1'b1;
          w_state_d     = StReq;
        end
      end

      StReq: begin
        w_tmo_enable = 1'b1;
        // ack/err are not meaningful before the slave has taken the request.
        if (w_tmo_expired) begin
          w_cyc_d       = 1'b0;
          w_stb_d       = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b1;
          w_rsp_dat_d   = '0;
          w_state_d     = StResp;
        end else if (!bus.wbm_stall_i) begin
          w_stb_d   = 1'b0;
          w_state_d = StWait;
        end
      end

      StWait: begin
        w_tmo_enable = 1'b1;
        if (bus.wbm_err_i) begin
          w_cyc_d       = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b1;
          w_rsp_dat_d   = '0;
          w_state_d     = StResp;
        end else if (bus.wbm_ack_i) begin
          w_cyc_d       = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b0;
          w_rsp_dat_d   = r_we_q ? '0 : bus.wbm_dat_i;
          w_state_d     = StResp;
        end else if (w_tmo_expired) begin
          w_cyc_d       = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b1;
          w_rsp_dat_d   = '0;
          w_state_d     = StResp;
        end
      end

      StResp: begin
        w_cmd_ready_d = 1'b1;
        w_state_d     = StIdle;
      end

      default: begin
        w_cyc_d       = 1'b0;
        w_stb_d       = 1'b0;
        w_cmd_ready_d = 1'b0;
        w_state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state_q     <= StIdle;
      r_cmd_ready_q <= 1'b0;
      r_rsp_valid_q <= 1'b0;
      r_rsp_err_q   <= 1'b0;
      r_rsp_dat_q   <= '0;
      r_cyc_q       <= 1'b0;
      r_stb_q       <= 1'b0;
      r_we_q        <= 1'b0;
      r_sel_q       <= '0;
      r_adr_q       <= '0;
      r_dat_q       <= '0;
    end else begin
      r_state_q     <= w_state_d;
      r_cmd_ready_q <= w_cmd_ready_d;
      r_rsp_valid_q <= w_rsp_valid_d;
      r_rsp_err_q   <= w_rsp_err_d;
      r_rsp_dat_q   <= w_rsp_dat_d;
      r_cyc_q       <= w_cyc_d;
      r_stb_q       <= w_stb_d;
      r_we_q        <= w_we_d;
      r_sel_q       <= w_sel_d;
      r_adr_q       <= w_adr_d;
      r_dat_q       <= w_dat_d;
    end
  end

  assign bus.cmd_ready_o = r_cmd_ready_q;
  assign bus.rsp_valid_o = r_rsp_valid_q;
  assign bus.rsp_err_o   = r_rsp_err_q;
  assign bus.rsp_dat_o   = r_rsp_dat_q;
  assign bus.wbm_cyc_o   = r_cyc_q;
  assign bus.wbm_stb_o   = r_stb_q;
  assign bus.wbm_we_o    = r_we_q;
  assign bus.wbm_sel_o   = r_sel_q;
  assign bus.wbm_adr_o   = r_adr_q;
  assign bus.wbm_dat_o   = r_dat_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master with TIMEOUT_CYCLES=8; the bench plays the slave by hand.
module tb_wishbone_master;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  wishbone_master_if u_bus ();

  wishbone_master #(
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (u_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sampling and driving both happen 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer a command for one edge; returns just after the accepting edge N.
  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
    u_bus.cmd_valid_i = 1'b1;
    u_bus.cmd_we_i    = we;
    u_bus.cmd_sel_i   = sel;
    u_bus.cmd_adr_i   = adr;
    u_bus.cmd_dat_i   = dat;
    tick();
    u_bus.cmd_valid_i = 1'b0;
    u_bus.cmd_adr_i   = 32'hFFFF_FFFF;
    u_bus.cmd_dat_i   = 32'hFFFF_FFFF;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    u_bus.cmd_valid_i = 1'b0;
    u_bus.cmd_we_i    = 1'b0;
    u_bus.cmd_sel_i   = 4'h0;
    u_bus.cmd_adr_i   = 32'h0;
    u_bus.cmd_dat_i   = 32'h0;
    u_bus.wbm_dat_i   = 32'h0;
    u_bus.wbm_ack_i   = 1'b0;
    u_bus.wbm_err_i   = 1'b0;
    u_bus.wbm_stall_i = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", 32'(u_bus.cmd_ready_o), 32'd0);
    check("rst_cyc", 32'(u_bus.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(u_bus.wbm_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(u_bus.rsp_err_o), 32'd0);
    check("rst_rsp_dat", u_bus.rsp_dat_o, 32'h0);
    check("rst_we", 32'(u_bus.wbm_we_o), 32'd0);
    check("rst_sel", 32'(u_bus.wbm_sel_o), 32'd0);
    check("rst_adr", u_bus.wbm_adr_o, 32'h0);
    check("rst_dat", u_bus.wbm_dat_o, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(u_bus.cmd_ready_o), 32'd1);

    // Write, no stall, ack one cycle after stb
    issue(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF);
    check("wr_cyc", 32'(u_bus.wbm_cyc_o), 32'd1);
    check("wr_stb", 32'(u_bus.wbm_stb_o), 32'd1);
    check("wr_we", 32'(u_bus.wbm_we_o), 32'd1);
    check("wr_sel", 32'(u_bus.wbm_sel_o), 32'hF);
    check("wr_adr", u_bus.wbm_adr_o, 32'h3000_0010);
    check("wr_dat", u_bus.wbm_dat_o, 32'hDEAD_BEEF);
    check("wr_ready_busy", 32'(u_bus.cmd_ready_o), 32'd0);
    tick();
    check("wr_stb_drop", 32'(u_bus.wbm_stb_o), 32'd0);
    check("wr_cyc_wait", 32'(u_bus.wbm_cyc_o), 32'd1);
    u_bus.wbm_dat_i = 32'hAAAA_5555;
    u_bus.wbm_ack_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    check("wr_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("wr_rsp_err", 32'(u_bus.rsp_err_o), 32'd0);
    check("wr_rsp_dat", u_bus.rsp_dat_o, 32'h0);
    check("wr_cyc_done", 32'(u_bus.wbm_cyc_o), 32'd0);
    check("wr_ready_resp", 32'(u_bus.cmd_ready_o), 32'd0);
    tick();
    check("wr_rsp_pulse", 32'(u_bus.rsp_valid_o), 32'd0);
    check("wr_ready_back", 32'(u_bus.cmd_ready_o), 32'd1);

    // Read returning 0x12345678
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    check("rd_we", 32'(u_bus.wbm_we_o), 32'd0);
    check("rd_stb", 32'(u_bus.wbm_stb_o), 32'd1);
    tick();
    u_bus.wbm_dat_i = 32'h1234_5678;
    u_bus.wbm_ack_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    check("rd_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("rd_rsp_dat", u_bus.rsp_dat_o, 32'h1234_5678);
    check("rd_rsp_err", 32'(u_bus.rsp_err_o), 32'd0);
    tick();
    check("rd_rsp_pulse", 32'(u_bus.rsp_valid_o), 32'd0);
    check("rd_ready_back", 32'(u_bus.cmd_ready_o), 32'd1);
    tick();
    check("rd_single_pulse", 32'(u_bus.rsp_valid_o), 32'd0);

    // Stall for 3 edges, then accept
    u_bus.wbm_stall_i = 1'b1;
    issue(1'b0, 4'h3, 32'h3000_0020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_stb_held", 32'(u_bus.wbm_stb_o), 32'd1);
      check("st_adr_stable", u_bus.wbm_adr_o, 32'h3000_0020);
      check("st_sel_stable", 32'(u_bus.wbm_sel_o), 32'h3);
    end
    u_bus.wbm_stall_i = 1'b0;
    tick();
    check("st_stb_drop", 32'(u_bus.wbm_stb_o), 32'd0);
    check("st_cyc_wait", 32'(u_bus.wbm_cyc_o), 32'd1);
    check("st_no_early_rsp", 32'(u_bus.rsp_valid_o), 32'd0);
    u_bus.wbm_dat_i = 32'hCAFE_F00D;
    u_bus.wbm_ack_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    check("st_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("st_rsp_dat", u_bus.rsp_dat_o, 32'hCAFE_F00D);
    tick();

    // Unmapped address: no ack, timeout after 8 cycles of cyc
    issue(1'b0, 4'hF, 32'h3000_00F0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_cyc_held", 32'(u_bus.wbm_cyc_o), 32'd1);
      check("to_no_rsp", 32'(u_bus.rsp_valid_o), 32'd0);
    end
    tick();
    check("to_cyc_drop", 32'(u_bus.wbm_cyc_o), 32'd0);
    check("to_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("to_rsp_err", 32'(u_bus.rsp_err_o), 32'd1);
    check("to_rsp_dat", u_bus.rsp_dat_o, 32'h0);
    tick();
    check("to_ready_back", 32'(u_bus.cmd_ready_o), 32'd1);

    // err and ack together: err wins
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    tick();
    u_bus.wbm_dat_i = 32'h55AA_55AA;
    u_bus.wbm_ack_i = 1'b1;
    u_bus.wbm_err_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    u_bus.wbm_err_i = 1'b0;
    check("err_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("err_rsp_err", 32'(u_bus.rsp_err_o), 32'd1);
    check("err_rsp_dat", u_bus.rsp_dat_o, 32'h0);
    tick();

    // ack on the timeout edge: normal completion
    issue(1'b0, 4'hF, 32'h3000_0014, 32'h0);
    tick();
    repeat (6) tick();
    check("ackto_cyc_held", 32'(u_bus.wbm_cyc_o), 32'd1);
    u_bus.wbm_dat_i = 32'h0BAD_CAFE;
    u_bus.wbm_ack_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    check("ackto_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("ackto_rsp_err", 32'(u_bus.rsp_err_o), 32'd0);
    check("ackto_rsp_dat", u_bus.rsp_dat_o, 32'h0BAD_CAFE);
    tick();

    // Reset during WAIT, then a fresh write
    issue(1'b1, 4'hF, 32'h3000_0018, 32'h1111_2222);
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_cyc", 32'(u_bus.wbm_cyc_o), 32'd0);
    check("mrst_stb", 32'(u_bus.wbm_stb_o), 32'd0);
    check("mrst_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd0);
    tick();
    check("mrst_no_rsp", 32'(u_bus.rsp_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_ready", 32'(u_bus.cmd_ready_o), 32'd1);
    issue(1'b1, 4'h5, 32'h3000_0040, 32'h0102_0304);
    check("post_adr", u_bus.wbm_adr_o, 32'h3000_0040);
    check("post_dat", u_bus.wbm_dat_o, 32'h0102_0304);
    check("post_sel", 32'(u_bus.wbm_sel_o), 32'h5);
    tick();
    u_bus.wbm_ack_i = 1'b1;
    tick();
    u_bus.wbm_ack_i = 1'b0;
    check("post_rsp_valid", 32'(u_bus.rsp_valid_o), 32'd1);
    check("post_rsp_err", 32'(u_bus.rsp_err_o), 32'd0);
    tick();
    check("post_ready_back", 32'(u_bus.cmd_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_master.md
# wishbone_master

Single-outstanding Wishbone pipelined-mode initiator that turns simple local read/write commands into bus cycles on the user-project Wishbone bus. It issues one transaction at a time, honours slave stall, and returns read data or an error status. It also bounds every cycle with a timeout so a missing or unmapped slave cannot hang the requester. It sits between on-chip control logic (sequencers, test engines) and Wishbone slave blocks such as the configuration/counter register slave.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles from bus-cycle start (cyc rise) to ack/err before abort; legal range 1..65535.

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-low reset (0 = reset)
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  4  byte lane selects
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  32  read data (0 for writes/errors)
- rsp_err_o  out  1  slave err or timeout; qualified by rsp_valid_o
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_sel_o  out  4  Wishbone SEL
- wbm_adr_o  out  32  Wishbone ADR
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK
- wbm_err_i  in  1  Wishbone ERR
- wbm_stall_i  in  1  Wishbone STALL

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready_o=1; on cmd_valid_i, register we/sel/adr/dat onto wbm_* outputs, clear timeout counter, go REQ.
- REQ: cyc=1, stb=1. If stall=0 at an edge, request is accepted: go WAIT (stb drops next cycle). If stall=1, hold REQ with all request fields stable.
- WAIT: cyc=1, stb=0. On ack: capture wbm_dat_i into rsp_dat_o if read (0 if write), rsp_err_o=0, go RESP. On err (ack and err both high: err wins): rsp_dat_o=0, rsp_err_o=1, go RESP. ack/err seen in REQ are ignored.
- Timeout: counter increments every cycle in REQ and WAIT; when it reaches TIMEOUT_CYCLES with no ack/err, drop cyc/stb, rsp_err_o=1, rsp_dat_o=0, go RESP. Ack arriving on the same edge as timeout wins (normal completion).
- RESP: cyc=0, rsp_valid_o=1 for exactly one cycle, then IDLE. No response backpressure; requester must sample the pulse.
- cmd_ready_o=0 in REQ, WAIT, RESP; commands offered then are not consumed.
- wbm_adr_o/sel/we/dat hold last command value outside REQ/WAIT (no requirement beyond stability).

## Timing
- Reset values: cmd_ready_o=1 after reset release (0 during reset), rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0; state IDLE.
- All outputs registered.
- Command accepted at edge N: cyc/stb high from N to N+1. No stall, ack registered by slave one cycle after stb: ack seen at edge N+2, rsp_valid_o high N+2 to N+3, cmd_ready_o high again N+3. Zero-stall back-to-back throughput: one transaction per 4 cycles.
- Each stall cycle adds one cycle; each ack-wait cycle adds one cycle.
- Reset asserted mid-transaction: at that edge cyc/stb drop, no response pulse, state IDLE.

## Structure
- Shared package wishbone_pkg: state enum (IDLE/REQ/WAIT/RESP), WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Timeout counter width = $clog2(TIMEOUT_CYCLES+1), local.
- One natural sub-module: wishbone_timeout (clear, enable, expired output); remainder a single FSM.

## Test plan
- Write 0xDEADBEEF, sel=0xF, adr=0x3000_0010 to responsive slave, no stall -> one cyc/stb cycle with those values, rsp_valid at N+2 edge, rsp_err=0, rsp_dat=0.
- Read adr=0x3000_0010 with slave returning 0x1234_5678 -> rsp_dat=0x1234_5678, rsp_err=0, exactly one rsp pulse.
- Stall held 3 cycles then released -> stb high 4 cycles, fields stable, response 3 cycles later than no-stall case.
- Unmapped adr=0x3000_00F0, no ack, TIMEOUT_CYCLES=8 -> cyc drops after 8 cycles, rsp_err=1, rsp_dat=0, cmd_ready returns.
- Slave asserts err (and ack same cycle) -> rsp_err=1, rsp_dat=0; ack arriving on timeout edge -> rsp_err=0.
- wb_rst_i=0 during WAIT -> cyc/stb/rsp_valid=0 next edge, no response; new command after release completes normally.
